// File: rtl/noc_sink_monitor.sv
// noc_sink_monitor
// Traffic sink and checker on the NI receive side of a NoC node. Accepts
// single-flit packets on an item/valid/busy handshake, checks header code,
// destination address and per-source sequence number, keeps saturating
// statistics, applies programmable back-pressure and toggles an LED heartbeat.
//
// Ports:
//   clkx          clock
//   reset         synchronous active-high reset
//   node_id       own node address (static after reset)
//   hold_cycles   extra busy cycles after each flit, sampled in CHECK
//   clr_stats     synchronous clear of counters, error flag and sequence table
//   in_data       flit {hdr, addr, payload}; payload = {src_id, seq}
//   in_valid      flit present
//   in_busy       sink busy; upstream holds data while high
//   rx_count      accepted flits (saturating)
//   err_hdr_count header errors (saturating)
//   err_dst_count destination errors (saturating)
//   err_seq_count sequence errors (saturating)
//   err_flag      sticky OR of all errors
//   heartbeat     LED toggle, period HB_PERIOD+1 cycles per half-wave
module noc_sink_monitor #(
    parameter int                HDR_SZ    = 2,
    parameter int                ADDR_SZ   = 4,
    parameter int                PL_SZ     = 16,
    parameter logic [HDR_SZ-1:0] HDR_DATA  = 2'b01,
    parameter int                HB_PERIOD = 1000
) (
    input  logic                            clkx,
    input  logic                            reset,
    input  logic [ADDR_SZ-1:0]              node_id,
    input  logic [7:0]                      hold_cycles,
    input  logic                            clr_stats,
    input  logic [HDR_SZ+ADDR_SZ+PL_SZ-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_busy,
    output logic [19:0]                     rx_count,
    output logic [15:0]                     err_hdr_count,
    output logic [15:0]                     err_dst_count,
    output logic [15:0]                     err_seq_count,
    output logic                            err_flag,
    output logic                            heartbeat
);
    localparam int SEQ_SZ  = PL_SZ - ADDR_SZ;
    localparam int FLIT_SZ = HDR_SZ + ADDR_SZ + PL_SZ;
    localparam int NSRC    = 1 << ADDR_SZ;
    localparam int HB_W    = $clog2(HB_PERIOD + 1);
    localparam logic [SEQ_SZ-1:0] SEQ_ONE = SEQ_SZ'(1);
    localparam logic [HB_W-1:0]   HB_TC   = HB_W'(HB_PERIOD);
    localparam logic [HB_W-1:0]   HB_ONE  = HB_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [7:0]           hold_cnt_r, hold_cnt_s;
    logic                 busy_s;
    logic                 accept_s;
    logic [FLIT_SZ-1:0]   flit_r;
    logic [SEQ_SZ-1:0]    exp_seq_r [NSRC];
    logic [HB_W-1:0]      hb_cnt_r;

    logic [HDR_SZ-1:0]    hdr_s;
    logic [ADDR_SZ-1:0]   addr_s;
    logic [ADDR_SZ-1:0]   src_s;
    logic [SEQ_SZ-1:0]    seq_s;
    logic                 hdr_bad_s;
    logic                 dst_bad_s;
    logic                 seq_bad_s;

    // Field extraction and error classification of the captured flit.
    always_comb begin
        hdr_s     = flit_r[FLIT_SZ-1 -: HDR_SZ];
        addr_s    = flit_r[PL_SZ +: ADDR_SZ];
        src_s     = flit_r[SEQ_SZ +: ADDR_SZ];
        seq_s     = flit_r[SEQ_SZ-1:0];
        hdr_bad_s = (hdr_s != HDR_DATA);
        dst_bad_s = (addr_s != node_id);
        seq_bad_s = (seq_s != exp_seq_r[src_s]);
    end

    // Next-state and busy logic of the handshake FSM.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        busy_s     = in_busy;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && !in_busy) begin
                    accept_s = 1'b1;
                    state_s  = ST_CHECK;
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            ST_CHECK: begin
                if (hold_cycles == 8'd0) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    hold_cnt_s = hold_cycles;
                    state_s    = ST_HOLD;
                    busy_s     = 1'b1;
                end
            end
            ST_HOLD: begin
                // Counter value 1 is the last HOLD cycle.
                if (hold_cnt_r <= 8'd1) begin
                    hold_cnt_s = 8'd0;
                    state_s    = ST_IDLE;
                    busy_s     = 1'b0;
                end else begin
                    hold_cnt_s = hold_cnt_r - 8'd1;
                    busy_s     = 1'b1;
                end
            end
            default: begin
                hold_cnt_s = 8'd0;
                state_s    = ST_IDLE;
                busy_s     = 1'b0;
            end
        endcase
    end

    // FSM state, hold counter and busy output registers.
    always_ff @(posedge clkx) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 8'd0;
            in_busy    <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            in_busy    <= busy_s;
        end
    end

    // Capture the flit on the accept edge.
    always_ff @(posedge clkx) begin
        if (reset) begin
            flit_r <= '0;
        end else if (accept_s) begin
            flit_r <= in_data;
        end else begin
            flit_r <= flit_r;
        end
    end

    // Statistics, sticky error flag and sequence table; clear beats CHECK.
    always_ff @(posedge clkx) begin
        if (reset || clr_stats) begin
            rx_count      <= 20'd0;
            err_hdr_count <= 16'd0;
            err_dst_count <= 16'd0;
            err_seq_count <= 16'd0;
            err_flag      <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                exp_seq_r[i] <= '0;
            end
        end else if (state_r == ST_CHECK) begin
            if (!(&rx_count)) begin
                rx_count <= rx_count + 20'd1;
            end
            if (hdr_bad_s) begin
                err_flag <= 1'b1;
                if (!(&err_hdr_count)) begin
                    err_hdr_count <= err_hdr_count + 16'd1;
                end
            end else if (dst_bad_s) begin
                err_flag <= 1'b1;
                if (!(&err_dst_count)) begin
                    err_dst_count <= err_dst_count + 16'd1;
                end
            end else begin
                // Table always resyncs to the received seq, error or not.
                exp_seq_r[src_s] <= seq_s + SEQ_ONE;
                if (seq_bad_s) begin
                    err_flag <= 1'b1;
                    if (!(&err_seq_count)) begin
                        err_seq_count <= err_seq_count + 16'd1;
                    end
                end
            end
        end
    end

    // Free-running heartbeat divider.
    always_ff @(posedge clkx) begin
        if (reset) begin
            hb_cnt_r  <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt_r == HB_TC) begin
            hb_cnt_r  <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt_r  <= hb_cnt_r + HB_ONE;
        end
    end
endmodule

// File: tb/tb_noc_sink_monitor.sv
// Directed self-checking bench for noc_sink_monitor (default parameters).
module tb_noc_sink_monitor;
    logic        clkx;
    logic        reset;
    logic [3:0]  node_id;
    logic [7:0]  hold_cycles;
    logic        clr_stats;
    logic [21:0] in_data;
    logic        in_valid;
    logic        in_busy;
    logic [19:0] rx_count;
    logic [15:0] err_hdr_count;
    logic [15:0] err_dst_count;
    logic [15:0] err_seq_count;
    logic        err_flag;
    logic        heartbeat;

    int tests_run;
    int tests_failed;
    int cyc;
    int last_acc;

    noc_sink_monitor dut (
        .clkx          (clkx),
        .reset         (reset),
        .node_id       (node_id),
        .hold_cycles   (hold_cycles),
        .clr_stats     (clr_stats),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_busy       (in_busy),
        .rx_count      (rx_count),
        .err_hdr_count (err_hdr_count),
        .err_dst_count (err_dst_count),
        .err_seq_count (err_seq_count),
        .err_flag      (err_flag),
        .heartbeat     (heartbeat)
    );

    initial clkx = 1'b0;
    always #5 clkx = ~clkx;

    // Cycle counter used to time accepts and heartbeat edges.
    always @(posedge clkx) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkx);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a flit and wait (bounded) for its accept edge.
    task automatic send(input logic [1:0] hdr, input logic [3:0] addr,
                        input logic [3:0] src, input logic [11:0] seq, input bit keep);
        bit done;
        done = 1'b0;
        in_data  = {hdr, addr, src, seq};
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!in_busy) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check_val("accept_timeout", 0, 1);
        last_acc = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    initial begin
        int prev_acc;
        int cnt;
        int hb_t0;
        logic hb_prev;
        bit seen;
        tests_run = 0; tests_failed = 0; cyc = 0; last_acc = 0;
        reset = 1'b1; node_id = 4'd1; hold_cycles = 8'd0; clr_stats = 1'b0;
        in_data = 22'd0; in_valid = 1'b0;
        idle(3);
        check_val("rst_busy", in_busy, 0);
        check_val("rst_rx", rx_count, 0);
        check_val("rst_errs", err_hdr_count + err_dst_count + err_seq_count, 0);
        check_val("rst_flag", err_flag, 0);
        check_val("rst_hb", heartbeat, 0);
        reset = 1'b0;
        tick();

        // Back-to-back with valid held: accepts 2 cycles apart.
        send(2'b01, 4'd1, 4'd0, 12'd0, 1'b1);
        for (int s = 1; s < 4; s++) begin
            prev_acc = last_acc;
            send(2'b01, 4'd1, 4'd0, 12'(s), 1'b1);
            check_val("b2b_spacing", last_acc - prev_acc, 2);
        end
        in_valid = 1'b0;
        idle(4);
        check_val("b2b_rx", rx_count, 4);
        check_val("b2b_hdr", err_hdr_count, 0);
        check_val("b2b_dst", err_dst_count, 0);
        check_val("b2b_seq", err_seq_count, 0);
        check_val("b2b_flag", err_flag, 0);

        // Sequence gap and resync.
        pulse_clr();
        send(2'b01, 4'd1, 4'd0, 12'd0, 1'b0); idle(3);
        send(2'b01, 4'd1, 4'd0, 12'd1, 1'b0); idle(3);
        send(2'b01, 4'd1, 4'd0, 12'd3, 1'b0); idle(3);
        check_val("gap_seq", err_seq_count, 1);
        send(2'b01, 4'd1, 4'd0, 12'd4, 1'b0); idle(3);
        check_val("resync_seq", err_seq_count, 1);
        check_val("gap_flag", err_flag, 1);
        check_val("gap_rx", rx_count, 4);

        // Destination and header errors leave the table alone.
        pulse_clr();
        send(2'b01, 4'd1, 4'd0, 12'd0, 1'b0); idle(3);
        send(2'b01, 4'd2, 4'd0, 12'd7, 1'b0); idle(3);
        send(2'b10, 4'd1, 4'd0, 12'd9, 1'b0); idle(3);
        send(2'b01, 4'd1, 4'd0, 12'd1, 1'b0); idle(3);
        check_val("dst_cnt", err_dst_count, 1);
        check_val("hdr_cnt", err_hdr_count, 1);
        check_val("dsthdr_seq", err_seq_count, 0);
        check_val("dsthdr_rx", rx_count, 4);

        // Seq wrap 4095 -> 0 is legal.
        send(2'b01, 4'd1, 4'd2, 12'd4095, 1'b0); idle(3);
        send(2'b01, 4'd1, 4'd2, 12'd0, 1'b0); idle(3);
        check_val("wrap_seq", err_seq_count, 1);

        // Hold=3: busy 4 cycles, accept spacing 5.
        pulse_clr();
        hold_cycles = 8'd3;
        send(2'b01, 4'd1, 4'd1, 12'd0, 1'b0);
        cnt = 0;
        while (in_busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check_val("hold_busy_len", cnt, 4);
        idle(2);
        send(2'b01, 4'd1, 4'd1, 12'd1, 1'b1);
        prev_acc = last_acc;
        send(2'b01, 4'd1, 4'd1, 12'd2, 1'b0);
        check_val("hold_spacing", last_acc - prev_acc, 5);
        idle(8);
        hold_cycles = 8'd0;

        // clr_stats coincident with CHECK drops that flit's updates.
        send(2'b01, 4'd1, 4'd3, 12'd5, 1'b0); idle(3);
        check_val("pre_clr_seq", err_seq_count, 1);
        send(2'b01, 4'd1, 4'd5, 12'd9, 1'b0);
        pulse_clr();
        idle(2);
        check_val("clr_rx", rx_count, 0);
        check_val("clr_seq", err_seq_count, 0);
        check_val("clr_flag", err_flag, 0);
        send(2'b01, 4'd1, 4'd3, 12'd0, 1'b0); idle(3);
        send(2'b01, 4'd1, 4'd5, 12'd0, 1'b0); idle(3);
        check_val("post_clr_seq", err_seq_count, 0);
        check_val("post_clr_rx", rx_count, 2);

        // Heartbeat half-period.
        for (int e = 0; e < 2; e++) begin
            hb_prev = heartbeat;
            seen = 1'b0;
            for (int i = 0; i < 1100; i++) begin
                tick();
                if (heartbeat != hb_prev) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) check_val("hb_timeout", 0, 1);
            if (e == 0) hb_t0 = cyc;
            else check_val("hb_period", cyc - hb_t0, 1001);
        end

        // Reset during HOLD.
        hold_cycles = 8'd3;
        send(2'b01, 4'd1, 4'd4, 12'd0, 1'b0);
        idle(2);
        check_val("hold_before_rst", in_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_hold_busy", in_busy, 0);
        check_val("rst_hold_rx", rx_count, 0);
        hold_cycles = 8'd0;
        prev_acc = cyc;
        send(2'b01, 4'd1, 4'd4, 12'd0, 1'b0);
        check_val("rst_hold_accept", last_acc - prev_acc, 1);
        idle(3);
        check_val("rst_hold_rx_after", rx_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
